phys_reg_alloc_ctrl: RTL and testbench
======================================

Name: phys_reg_alloc_ctrl

Overview:
- Controls the physical-register free list for the register-renaming stage.
- Hands out free physical registers to rename on a valid/ready handshake, takes freed registers back at commit, and keeps an in-order queue of branch checkpoints.
- On a branch mispredict it rolls the free list back to the checkpoint of the oldest unresolved branch.
- Sits between decode/rename, the commit (graduation) logic, and the EX branch-resolution path.

Parameters:
- NUM_ARCH_REGS, 32, architectural register count.
- NUM_PHYS_REGS, 64, physical register count; free-list depth DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS.
- NUM_CKPT, 4, maximum number of outstanding branch checkpoints.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_req  in  1  rename requests one physical register
- alloc_ready  out  1  a register can be granted this cycle
- alloc_preg  out  $clog2(NUM_PHYS_REGS)  granted register; valid when alloc_req & alloc_ready
- free_valid  in  1  commit returns a register
- free_preg  in  $clog2(NUM_PHYS_REGS)  register being returned
- ckpt_req  in  1  take a branch checkpoint this cycle
- ckpt_ready  out  1  a checkpoint slot is available
- ckpt_id  out  $clog2(NUM_CKPT)  slot index assigned to the checkpoint
- resolve_valid  in  1  oldest outstanding branch resolved
- resolve_mispredict  in  1  qualifies resolve_valid; 1 = mispredicted
- free_count  out  $clog2(DEPTH)+1  number of registers in the free list
- ckpt_count  out  $clog2(NUM_CKPT)+1  number of outstanding checkpoints
- init_done  out  1  initialisation complete
- overflow_err  out  1  sticky; set by a free while full or a checkpoint/resolve protocol violation

Behaviour:
- Storage:
  - Circular buffer mem[DEPTH] with head (read) and tail (write) pointers, each $clog2(DEPTH)+1 bits including a wrap bit.
  - free_count = tail - head. Empty when head == tail; full when the indices are equal and the wrap bits differ.
- Reset (async):
  - head = 0, tail = 0, state = INIT, init index = 0.
  - Checkpoint queue emptied; overflow_err = 0; init_done = 0.
  - alloc_ready = 0, ckpt_ready = 0.
- FSM state INIT:
  - Writes mem[i] = NUM_ARCH_REGS + i, one entry per cycle, tail increments each cycle.
  - After DEPTH cycles (32 by default): state goes to RUN and init_done = 1, with head = 0 and the list full.
  - alloc, ckpt, free and resolve inputs are ignored in INIT.
- FSM state RUN, allocation:
  - alloc_ready = !empty & !mispredict_now, where mispredict_now = resolve_valid & resolve_mispredict. Combinational.
  - alloc_preg = mem[head[idx]].
  - Fire = alloc_req & alloc_ready; head increments on the next edge. The pointer wraps modulo DEPTH and the wrap bit toggles.
- Free:
  - When free_valid: mem[tail] = free_preg and tail increments, applied the same cycle as any alloc or restore.
  - free_valid while full: write dropped and overflow_err set.
- Checkpoint:
  - ckpt_ready = (ckpt_count < NUM_CKPT) & !mispredict_now.
  - On ckpt_req & ckpt_ready: store the head value after any same-cycle alloc (checkpoint includes that alloc) into slot ckpt_wptr; ckpt_id = ckpt_wptr; ckpt_wptr and ckpt_count increment.
  - ckpt_req while not ready: ignored and overflow_err set.
- Resolve: branches resolve in order, so the oldest checkpoint is at ckpt_rptr.
  - Correct prediction: pop the oldest entry (ckpt_rptr++, ckpt_count--).
  - Mispredict: head = saved head of the oldest entry and all checkpoints are cleared (ckpt_wptr = ckpt_rptr, ckpt_count = 0). A free_valid in the same cycle is still applied to tail.
  - resolve_valid with ckpt_count == 0: ignored and overflow_err set.
- Simultaneous resolve-correct and ckpt_req: pop and push both apply, so ckpt_count is unchanged.
- All state updates are registered; outputs reflect state one cycle after the causing edge. The exceptions are alloc_ready and ckpt_ready, which also depend combinationally on mispredict_now.
- Reset asserted mid-operation returns the block to INIT regardless of state.

Optional Feature:
- Macro: ALLOC_BYPASS_EN.
- Defined: when the list is empty and free_valid is high, alloc_ready = 1 and alloc_preg = free_preg. On fire, the freed entry is consumed directly: neither tail nor head moves and free_count stays 0.
- Undefined: alloc_ready = 0 whenever the list is empty; the freed register becomes allocatable on the following cycle.

Test Plan:
- Reset then idle -> init_done rises 32 cycles after rst_n deasserts; free_count = 32; first allocations return 32, 33, 34.
- 32 back-to-back allocs -> alloc_ready = 0 and free_count = 0; then free_valid with free_preg = 5 -> next alloc returns 5 (same cycle if ALLOC_BYPASS_EN, otherwise next cycle).
- Alloc 32, 33; ckpt_req (id 0) with alloc 34; alloc 35, 36; resolve mispredict -> head restored so next alloc returns 35; free_count = 29; ckpt_count = 0.
- Four checkpoints -> ckpt_ready = 0; fifth ckpt_req -> overflow_err = 1; one resolve-correct -> ckpt_count = 3, ckpt_ready = 1, next ckpt_id = 0 (wrap).
- From full, free_valid with free_preg = 7 -> free_count stays 32 and overflow_err = 1.
- Assert rst_n low mid-RUN with 3 checkpoints outstanding -> ckpt_count = 0, init_done = 0, alloc_ready = 0; INIT sequence replays.

Source files
------------

// File: rtl/phys_reg_alloc_ctrl_if.sv
// rtl/phys_reg_alloc_ctrl_if.sv - rename/commit/branch-resolution bus of the physical-register allocator
//
// Purpose: bundles every handshake and status signal of phys_reg_alloc_ctrl.
//   master: the rename, commit and EX branch-resolution side.
//   slave : the allocator itself.
// Signals (master -> slave):
//   alloc_req, free_valid, free_preg, ckpt_req, resolve_valid, resolve_mispredict
// Signals (slave -> master):
//   alloc_ready, alloc_preg, ckpt_ready, ckpt_id, free_count, ckpt_count,
//   init_done, overflow_err
interface phys_reg_alloc_ctrl_if #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_CKPT      = 4
);
  localparam int DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PREG_W = $clog2(NUM_PHYS_REGS);
  localparam int CK_W   = $clog2(NUM_CKPT);
  localparam int FC_W   = $clog2(DEPTH) + 1;
  localparam int CKC_W  = $clog2(NUM_CKPT) + 1;

  logic              alloc_req;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              ckpt_req;
  logic              ckpt_ready;
  logic [CK_W-1:0]   ckpt_id;
  logic              resolve_valid;
  logic              resolve_mispredict;
  logic [FC_W-1:0]   free_count;
  logic [CKC_W-1:0]  ckpt_count;
  logic              init_done;
  logic              overflow_err;

  modport master (
    output alloc_req, free_valid, free_preg, ckpt_req, resolve_valid, resolve_mispredict,
    input  alloc_ready, alloc_preg, ckpt_ready, ckpt_id, free_count, ckpt_count,
           init_done, overflow_err
  );

  modport slave (
    input  alloc_req, free_valid, free_preg, ckpt_req, resolve_valid, resolve_mispredict,
    output alloc_ready, alloc_preg, ckpt_ready, ckpt_id, free_count, ckpt_count,
           init_done, overflow_err
  );
endinterface

// File: rtl/phys_reg_alloc_ctrl.sv
// rtl/phys_reg_alloc_ctrl.sv - physical-register free list with branch checkpoint rollback
//
// Purpose: circular free list of DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS entries.
//   INIT fills it with NUM_ARCH_REGS..NUM_PHYS_REGS-1, RUN grants registers to
//   rename, accepts freed registers from commit, and keeps an in-order queue of
//   saved head pointers so a mispredict can roll the list back.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, returns the block to INIT
//   bus   - phys_reg_alloc_ctrl_if.slave (alloc / free / checkpoint / resolve / status)
// Optional feature: define ALLOC_BYPASS_EN to let an empty list grant the
//   register being freed in the same cycle.
module phys_reg_alloc_ctrl #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_CKPT      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  phys_reg_alloc_ctrl_if.slave bus
);
  localparam int DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int PREG_W = $clog2(NUM_PHYS_REGS);
  localparam int CK_W   = $clog2(NUM_CKPT);
  localparam int CKC_W  = CK_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [CK_W-1:0]  LAST_CKPT = CK_W'(NUM_CKPT - 1);

  typedef enum logic [0:0] {S_INIT, S_RUN} state_e;

  // Index wraps modulo DEPTH; the top bit toggles on each wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p[IDX_W-1:0] == LAST_IDX) r = {~p[PTR_W-1], {IDX_W{1'b0}}};
    else                          r = p + PTR_W'(1);
    return r;
  endfunction

  function automatic logic [CK_W-1:0] ckpt_inc(input logic [CK_W-1:0] p);
    return (p == LAST_CKPT) ? '0 : p + CK_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  init_idx_q, init_idx_d;
  logic              init_done_q, init_done_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CK_W-1:0]   ckpt_wptr_q, ckpt_wptr_d, ckpt_rptr_q, ckpt_rptr_d;
  logic [CKC_W-1:0]  ckpt_count_q, ckpt_count_d;
  logic              err_q, err_d;

  logic [PREG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ckpt_head [NUM_CKPT];

  logic              mem_we, ckpt_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [PREG_W-1:0] mem_wdata;
  logic [PTR_W-1:0]  head_after_alloc;

  logic run, empty, full, mispredict_now, alloc_fire, pop_fire;
  logic free_wr, ckpt_push, resolve_hit, resolve_err;

  assign run            = (state_q == S_RUN);
  assign mispredict_now = bus.resolve_valid & bus.resolve_mispredict;
  assign empty          = (head_q == tail_q);
  assign full           = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &
                          (head_q[PTR_W-1] != tail_q[PTR_W-1]);

`ifdef ALLOC_BYPASS_EN
  logic bypass_avail;
  assign bypass_avail    = empty & bus.free_valid;
  assign bus.alloc_ready = run & ~mispredict_now & (~empty | bypass_avail);
  assign bus.alloc_preg  = bypass_avail ? bus.free_preg : mem[head_q[IDX_W-1:0]];
`else
  assign bus.alloc_ready = run & ~mispredict_now & ~empty;
  assign bus.alloc_preg  = mem[head_q[IDX_W-1:0]];
`endif

  assign alloc_fire = bus.alloc_req & bus.alloc_ready;
  // A grant from an empty list can only be the bypassed free: it consumes the
  // freed register directly, so neither pointer moves.
  assign pop_fire   = alloc_fire & ~empty;
  assign free_wr    = run & bus.free_valid & ~full & ~(alloc_fire & empty);
  assign head_after_alloc = pop_fire ? ptr_inc(head_q) : head_q;

  assign bus.ckpt_ready = run & (ckpt_count_q < CKC_W'(NUM_CKPT)) & ~mispredict_now;
  assign ckpt_push      = bus.ckpt_req & bus.ckpt_ready;
  assign resolve_hit    = run & bus.resolve_valid & (ckpt_count_q != '0);
  assign resolve_err    = run & bus.resolve_valid & (ckpt_count_q == '0);

  always_comb begin
    if (head_q[PTR_W-1] == tail_q[PTR_W-1])
      bus.free_count = {1'b0, tail_q[IDX_W-1:0]} - {1'b0, head_q[IDX_W-1:0]};
    else
      bus.free_count = PTR_W'(DEPTH) - {1'b0, head_q[IDX_W-1:0]} + {1'b0, tail_q[IDX_W-1:0]};
  end

  assign bus.ckpt_id      = ckpt_wptr_q;
  assign bus.ckpt_count   = ckpt_count_q;
  assign bus.init_done    = init_done_q;
  assign bus.overflow_err = err_q;

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    init_done_d  = init_done_q;
    head_d       = head_q;
    tail_d       = tail_q;
    ckpt_wptr_d  = ckpt_wptr_q;
    ckpt_rptr_d  = ckpt_rptr_q;
    ckpt_count_d = ckpt_count_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_waddr    = tail_q[IDX_W-1:0];
    mem_wdata    = bus.free_preg;
    ckpt_we      = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_wdata  = PREG_W'(NUM_ARCH_REGS) + PREG_W'(init_idx_q);
        tail_d     = ptr_inc(tail_q);
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == LAST_IDX) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      default: begin
        head_d = head_after_alloc;
        if (free_wr) begin
          mem_we = 1'b1;
          tail_d = ptr_inc(tail_q);
        end
        if (ckpt_push) begin
          ckpt_we      = 1'b1;
          ckpt_wptr_d  = ckpt_inc(ckpt_wptr_q);
          ckpt_count_d = ckpt_count_q + CKC_W'(1);
        end
        if (resolve_hit) begin
          if (bus.resolve_mispredict) begin
            // alloc and ckpt are both blocked this cycle, so the restore wins.
            head_d       = ckpt_head[ckpt_rptr_q];
            ckpt_wptr_d  = ckpt_rptr_q;
            ckpt_count_d = '0;
          end else begin
            ckpt_rptr_d  = ckpt_inc(ckpt_rptr_q);
            ckpt_count_d = ckpt_count_d - CKC_W'(1);
          end
        end
        if ((bus.free_valid & full) | resolve_err | (bus.ckpt_req & ~bus.ckpt_ready))
          err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      init_done_q  <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      ckpt_wptr_q  <= '0;
      ckpt_rptr_q  <= '0;
      ckpt_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      init_done_q  <= init_done_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      ckpt_wptr_q  <= ckpt_wptr_d;
      ckpt_rptr_q  <= ckpt_rptr_d;
      ckpt_count_q <= ckpt_count_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: INIT rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (mem_we)  mem[mem_waddr]         <= mem_wdata;
    if (ckpt_we) ckpt_head[ckpt_wptr_q] <= head_after_alloc;
  end
endmodule

// File: tb/tb_phys_reg_alloc_ctrl.sv
// tb/tb_phys_reg_alloc_ctrl.sv - directed-vector bench for phys_reg_alloc_ctrl
module tb_phys_reg_alloc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vectors = 0;
  int   n_miscompares = 0;
  int   cyc;

  always #5 clk = ~clk;

  phys_reg_alloc_ctrl_if bus_if ();

  phys_reg_alloc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.alloc_req          = 1'b0;
    bus_if.free_valid         = 1'b0;
    bus_if.free_preg          = '0;
    bus_if.ckpt_req           = 1'b0;
    bus_if.resolve_valid      = 1'b0;
    bus_if.resolve_mispredict = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    cyc = 0;
    while (!bus_if.init_done && cyc < 100) begin
      tick();
      cyc++;
    end
    check(tag, cyc, 32);
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(tag);
  endtask

  initial begin
    idle_inputs();
    #12;
    check("rst_init_done", bus_if.init_done, 0);
    check("rst_alloc_ready", bus_if.alloc_ready, 0);
    check("rst_ckpt_ready", bus_if.ckpt_ready, 0);
    check("rst_ckpt_count", bus_if.ckpt_count, 0);
    check("rst_free_count", bus_if.free_count, 0);
    check("rst_overflow", bus_if.overflow_err, 0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_cycles");
    check("init_free_count", bus_if.free_count, 32);
    check("init_alloc_ready", bus_if.alloc_ready, 1);
    check("init_ckpt_ready", bus_if.ckpt_ready, 1);

    // Drain the whole list; pointer wraps back to index 0.
    for (int i = 0; i < 32; i++) begin
      bus_if.alloc_req = 1'b1;
      #1;
      check("drain_ready", bus_if.alloc_ready, 1);
      check("drain_preg", bus_if.alloc_preg, 32 + i);
      tick();
    end
    bus_if.alloc_req = 1'b0;
    #1;
    check("empty_ready", bus_if.alloc_ready, 0);
    check("empty_count", bus_if.free_count, 0);

    bus_if.free_valid = 1'b1;
    bus_if.free_preg  = 6'd5;
    #1;
`ifdef ALLOC_BYPASS_EN
    check("bypass_ready", bus_if.alloc_ready, 1);
    check("bypass_preg", bus_if.alloc_preg, 5);
    bus_if.alloc_req = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("bypass_count", bus_if.free_count, 0);
    check("bypass_after_ready", bus_if.alloc_ready, 0);
`else
    check("nobypass_ready", bus_if.alloc_ready, 0);
    tick();
    idle_inputs();
    #1;
    check("free_count_1", bus_if.free_count, 1);
    check("free_ready", bus_if.alloc_ready, 1);
    check("free_preg5", bus_if.alloc_preg, 5);
    bus_if.alloc_req = 1'b1;
    tick();
    bus_if.alloc_req = 1'b0;
    #1;
    check("refree_count", bus_if.free_count, 0);
`endif

    // Checkpoint with same-cycle alloc, then mispredict rollback.
    do_reset("reinit_cycles");
    bus_if.alloc_req = 1'b1;
    tick();
    tick();
    bus_if.ckpt_req = 1'b1;
    #1;
    check("ck_ready", bus_if.ckpt_ready, 1);
    check("ck_id0", bus_if.ckpt_id, 0);
    check("ck_alloc_preg", bus_if.alloc_preg, 34);
    tick();
    bus_if.ckpt_req = 1'b0;
    #1;
    check("ck_count1", bus_if.ckpt_count, 1);
    check("post_ck_preg", bus_if.alloc_preg, 35);
    tick();
    tick();
    bus_if.alloc_req          = 1'b0;
    bus_if.resolve_valid      = 1'b1;
    bus_if.resolve_mispredict = 1'b1;
    #1;
    check("mp_alloc_ready", bus_if.alloc_ready, 0);
    check("mp_ckpt_ready", bus_if.ckpt_ready, 0);
    check("pre_mp_count", bus_if.free_count, 27);
    tick();
    idle_inputs();
    #1;
    check("mp_preg", bus_if.alloc_preg, 35);
    check("mp_free_count", bus_if.free_count, 29);
    check("mp_ckpt_count", bus_if.ckpt_count, 0);
    check("mp_overflow", bus_if.overflow_err, 0);

    // Fill the checkpoint queue, overflow it, then pop and wrap the slot index.
    for (int i = 0; i < 4; i++) begin
      bus_if.ckpt_req = 1'b1;
      #1;
      check("ck4_id", bus_if.ckpt_id, i);
      tick();
    end
    bus_if.ckpt_req = 1'b0;
    #1;
    check("ck4_count", bus_if.ckpt_count, 4);
    check("ck4_ready", bus_if.ckpt_ready, 0);
    check("ck4_overflow", bus_if.overflow_err, 0);
    bus_if.ckpt_req = 1'b1;
    tick();
    bus_if.ckpt_req = 1'b0;
    #1;
    check("ck5_overflow", bus_if.overflow_err, 1);
    check("ck5_count", bus_if.ckpt_count, 4);
    bus_if.resolve_valid = 1'b1;
    tick();
    bus_if.resolve_valid = 1'b0;
    #1;
    check("rc_count", bus_if.ckpt_count, 3);
    check("rc_ready", bus_if.ckpt_ready, 1);
    check("rc_id_wrap", bus_if.ckpt_id, 0);
    bus_if.resolve_valid = 1'b1;
    bus_if.ckpt_req      = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("pushpop_count", bus_if.ckpt_count, 3);
    check("pushpop_id", bus_if.ckpt_id, 1);

    // Asynchronous reset mid-RUN with three checkpoints outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ckpt_count", bus_if.ckpt_count, 0);
    check("midrst_init_done", bus_if.init_done, 0);
    check("midrst_alloc_ready", bus_if.alloc_ready, 0);
    check("midrst_overflow", bus_if.overflow_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("replay_cycles");
    check("replay_count", bus_if.free_count, 32);
    check("replay_preg", bus_if.alloc_preg, 32);

    // Free while full is dropped and flagged.
    bus_if.free_valid = 1'b1;
    bus_if.free_preg  = 6'd7;
    tick();
    idle_inputs();
    #1;
    check("full_free_count", bus_if.free_count, 32);
    check("full_free_overflow", bus_if.overflow_err, 1);
    check("full_free_preg", bus_if.alloc_preg, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
